// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package countdown_pkg;

    // Timer control states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } countdown_state_t;

    // 50 MHz board clock -> one tick per second.
    localparam int TICK_DIV_DEFAULT = 50_000_000;

    // Short tick period for simulation.
    localparam int TICK_DIV_SIM = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler: counts enabled cycles 0..TICK_DIV-1 and flags the last one.
// Latency: tick is combinational from the registered count and enable.
// Backpressure: none; enable low freezes the count, clear forces it to 0.
//
// Ports:
//   clk, reset_n : clock and synchronous active-low reset
//   clear        : force count to 0 on the next edge (wins over enable)
//   enable       : advance the count; low holds the current phase
//   tick         : high when count == TICK_DIV-1 and enable is high
module tick_prescaler
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int                CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = enable && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter: decrements once per TICK_DIV cycles, pulses done on expiry.
// Latency: all outputs registered; load/start/pause take effect on the sampling edge.
// Backpressure: none; inputs prioritised reset_n > load > pause > start every cycle.
//
// Ports:
//   clk, reset_n      : clock and synchronous active-low reset
//   init, load        : load captures init into the count and the reload register
//   start, pause      : begin/resume and freeze counting
//   out, running, done: current count, RUN indicator, one-cycle expiry pulse
// Build option: COUNTDOWN_TIMER_AUTORELOAD_EN reloads the count on expiry and
// keeps running instead of stopping in EXPIRED.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] init,
    input  logic             load,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] out,
    output logic             running,
    output logic             done
);

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    localparam bit AUTORELOAD_EN = 1'b1;
`else
    localparam bit AUTORELOAD_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    countdown_state_t state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    logic tick;
    logic psc_clear;
    logic psc_enable;

    // The prescaler only advances in cycles where RUN actually continues, so a
    // tick coinciding with pause (or load) is lost and its phase is held.
    assign psc_enable = (state_q == ST_RUN) && !load && !pause;
    // Fresh starts from IDLE begin a full tick period; resumes from PAUSED do not.
    assign psc_clear  = load ||
                        ((state_q == ST_IDLE) && start && !pause && (out_q != '0));

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (psc_clear),
        .enable  (psc_enable),
        .tick    (tick)
    );

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load) begin
            out_d    = init;
            reload_d = init;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A zero count cannot run, so start is silently ignored.
                    if (start && !pause && (out_q != '0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (tick) begin
                        if (out_q > ONE) begin
                            out_d = out_q - ONE;
                        end else begin
                            done_d = 1'b1;
                            if (AUTORELOAD_EN && (reload_q != '0)) begin
                                out_d = reload_q;
                            end else begin
                                out_d   = '0;
                                state_d = ST_EXPIRED;
                            end
                        end
                    end
                end
                ST_PAUSED: begin
                    if (start && !pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    // Held at zero until load or reset.
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            out_q     <= '0;
            reload_q  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            reload_q  <= reload_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign out     = out_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer with TICK_DIV = 4, WIDTH = 4.
// Directed scenarios followed by randomized control traffic; a reference model
// tracks "cycles left until next decrement" and a monitor checks every cycle.
module tb_countdown_timer;
    import countdown_pkg::*;

    localparam int W    = 4;
    localparam int TDIV = TICK_DIV_SIM;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] init;
    logic         load;
    logic         start;
    logic         pause;
    logic [W-1:0] out;
    logic         running;
    logic         done;

    countdown_timer #(
        .WIDTH    (W),
        .TICK_DIV (TDIV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (init),
        .load    (load),
        .start   (start),
        .pause   (pause),
        .out     (out),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] out;
        logic         running;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    typedef enum {M_IDLE, M_RUN, M_PAUSED, M_EXPIRED} mstate_t;
    mstate_t m_state = M_IDLE;
    int      m_val    = 0;
    int      m_reload = 0;
    int      m_left   = TDIV;   // running cycles remaining until the next decrement
    bit      m_done   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // One clock cycle of stimulus; model predicts outputs after the next edge.
    task automatic step(input bit rn, input bit ld, input int iv, input bit st, input bit ps);
        exp_t e;
        @(negedge clk);
        reset_n = rn;
        load    = ld;
        init    = W'(iv);
        start   = st;
        pause   = ps;
        m_done  = 0;
        if (!rn) begin
            m_state = M_IDLE; m_val = 0; m_reload = 0; m_left = TDIV;
        end else if (ld) begin
            m_val = iv % (1 << W); m_reload = m_val; m_left = TDIV; m_state = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE: if (st && !ps && m_val != 0) begin
                    m_state = M_RUN; m_left = TDIV;
                end
                M_RUN: if (ps) begin
                    m_state = M_PAUSED;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_left = TDIV;
                        if (m_val > 1) begin
                            m_val = m_val - 1;
                        end else begin
                            m_done = 1;
                            if (AR && m_reload != 0) begin
                                m_val = m_reload;
                            end else begin
                                m_val = 0; m_state = M_EXPIRED;
                            end
                        end
                    end
                end
                M_PAUSED: if (st && !ps) m_state = M_RUN;
                default: ;
            endcase
        end
        e.out     = W'(m_val);
        e.running = (m_state == M_RUN);
        e.done    = m_done;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are registered, so one expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out",     out,          e.out);
                chk("running", W'(running),  W'(e.running));
                chk("done",    W'(done),     W'(e.done));
            end
        end
    end

    initial begin
        reset_n = 1'b0; init = '0; load = 0; start = 0; pause = 0;

        // Reset, then load 5 and count to expiry.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 5, 0, 0);
        step(1, 0, 0, 1, 0);
        idle(26);

        // Expired: start and pause ignored.
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1);
        idle(6);

        // Pause/resume.
        step(1, 1, 9, 0, 0);
        step(1, 0, 0, 1, 0);
        idle(5);
        step(1, 0, 0, 0, 1);
        idle(10);
        step(1, 0, 0, 1, 0);
        idle(8);

        // Pause on the tick cycle: tick lost, fires right after resume.
        step(1, 1, 6, 0, 0);
        step(1, 0, 0, 1, 0);
        idle(3);
        step(1, 0, 0, 0, 1);
        idle(3);
        step(1, 0, 0, 1, 0);
        idle(3);

        // Zero start.
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        idle(8);

        // Load mid-run, then restart.
        step(1, 1, 7, 0, 0);
        step(1, 0, 0, 1, 0);
        idle(2);
        step(1, 1, 3, 0, 0);
        idle(5);
        step(1, 0, 0, 1, 0);
        idle(3);

        // start+pause together in RUN, then reset mid-run.
        step(1, 0, 0, 1, 1);
        idle(4);
        step(1, 0, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 0);
        idle(3);

        // Autoreload-style sequence (plain expiry when the option is off).
        step(1, 1, 2, 0, 0);
        step(1, 0, 0, 1, 0);
        idle(20);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 39) == 0),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 11) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", W'(exp_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
